serv_dbus_ram: RTL and testbench
================================

# serv_dbus_ram

Wishbone classic data-bus responder for the SERV core: the slave end of the core's data bus, driven by the word-aligned address, write data and byte selects that the core's buffer and memory-interface logic produce. It holds a word-organised RAM with byte-enable writes and adds a configurable number of wait states so the core's stall handling can be exercised. An out-of-range address is still acknowledged and is reported through a sticky error flag. This keeps the core from hanging on a bad address.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`: word-index width; derived, not overridden.
- `WAIT`, 1: wait states inserted before ack; legal range 0..15.
- `BASE`, 32'h0000_0000: byte base address of the RAM; aligned to DEPTH*4.

- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_wb_adr`  in  32  byte address; bits [1:0] are ignored.
- `i_wb_dat`  in  32  write data.
- `i_wb_sel`  in  4  byte enables; bit n covers bits [8n+7:8n].
- `i_wb_we`  in  1  1 = write, 0 = read.
- `i_wb_cyc`  in  1  request valid; doubles as stb.
- `o_wb_rdt`  out  32  read data; valid only while `o_wb_ack` = 1.
- `o_wb_ack`  out  1  one-cycle acknowledge.
- `o_oor`  out  1  sticky out-of-range flag.
- `i_oor_clr`  in  1  clears `o_oor`.

## Operation
- **States:** IDLE, BUSY, ACK. Wait counter `cnt` is 4 bits.
- **IDLE:**
  - With `i_wb_cyc` = 1: capture adr, dat, sel and we into request registers, load `cnt` = WAIT, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY:**
  - With `i_wb_cyc` = 0: abort. Go to IDLE; no access and no ack.
  - With `cnt` != 0: decrement `cnt`.
  - With `cnt` = 0: perform the access, set ack, go to ACK.
- **ACK:** clear ack and go to IDLE unconditionally.
  - A `cyc` still high at the next IDLE edge is treated as a new request.
- **Range check:** `off` = captured adr − BASE, computed modulo 2^32. The request is in range iff `off[31:2]` < DEPTH. Word index = `off[AW+1:2]`.
- **Read, in range:** `o_wb_rdt` = the full stored word. `sel` is ignored on reads.
- **Write, in range:** update each byte whose `sel` bit is set; keep the other bytes. `o_wb_rdt` = 0 during a write ack.
- **Out of range:**
  - Ack is given normally and `o_wb_rdt` = 0.
  - A write leaves the RAM unchanged.
  - `o_oor` is set on the access edge.
- **`o_oor` control:**
  - `i_oor_clr` = 1 clears it on the next edge.
  - A set and a clear on the same edge: set wins.
- **Request registers:** captured only on the IDLE→BUSY edge. Input changes during BUSY do not affect the access.

## Timing
- **Reset values:**
  - State = IDLE, `cnt` = 0.
  - `o_wb_ack` = 0, `o_wb_rdt` = 0, `o_oor` = 0.
  - RAM contents are not reset.
- **Reset effect:** assertion takes effect immediately, with no clock. Any in-flight write is discarded. Release is sampled at the next edge.
- **Latency:** with `cyc` sampled high at edge E0, `o_wb_ack` is high for exactly the cycle after edge E0+1+WAIT.
  - WAIT = 0: ack follows edge E0+1.
  - Read data and ack are registered, with no combinational path from inputs to outputs.
- **Outside ack:** `o_wb_rdt` = 0.
- **Throughput:** a master holding `cyc` high continuously gets one access every WAIT+3 cycles.
  - SERV drops `cyc` in the ack cycle, so back-to-back SERV accesses cost WAIT+2 bus cycles after the request.
- **RAM write timing:** the write lands on the same edge that raises ack. A read issued afterwards returns the new data.

## Test plan
- **Basic write/readback:** reset, then write 32'hDEAD_BEEF to address BASE+8 with sel = 4'hF, WAIT = 1, then read it back.
  - Each ack arrives 3 edges after `cyc` is first sampled.
  - The read returns 32'hDEAD_BEEF.
- **Byte-enable write:** write 32'h1122_3344 with sel = 4'b0101 over a word holding 32'hAAAA_AAAA, then read it back. Read returns 32'hAA22_AA44.
- **Out-of-range write:** with DEPTH = 256, write to address BASE+1024.
  - Ack is given and `o_wb_rdt` = 0.
  - A read of BASE+0 returns its old value.
  - `o_oor` = 1 and stays 1.
  - `i_oor_clr` pulse: `o_oor` = 0 on the next edge.
  - `i_oor_clr` on the same edge as a new out-of-range access: `o_oor` stays 1.
- **Abort:** with WAIT = 3, drop `cyc` after 2 cycles of BUSY on a write to BASE+4 with data 32'h5555_5555.
  - No ack.
  - A following read of BASE+4 returns its previous value.
- **Reset mid-access:** assert `i_rst` asynchronously during BUSY of a write.
  - `o_wb_ack` = 0 and `o_wb_rdt` = 0 immediately.
  - Later reads show no write took place.
  - After release, a new read completes with normal latency.
- **Zero wait states:** with WAIT = 0, issue 4 back-to-back SERV-style reads, each dropping `cyc` on ack.
  - Each ack arrives exactly 2 edges after its `cyc` is sampled.
  - Each returns the correct data.

Source files
------------

// File: rtl/serv_dbus_ram_if.sv
// Wishbone classic data-bus bundle between the SERV core (master) and a
// word-organised RAM responder (slave), plus the responder's sticky
// out-of-range flag, its clear input and a state observation port.
//
// Handshake: wb_cyc doubles as stb and is the request valid. The master holds
// wb_cyc and the request fields stable until it sees wb_ack, which is high for
// exactly one cycle per completed access. wb_rdt is valid only while wb_ack is
// high and is 0 otherwise. Dropping wb_cyc before ack abandons the request with
// no access and no ack.
`timescale 1ns/1ps

interface serv_dbus_ram_if;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        oor;
  logic        oor_clr;
  logic [1:0]  dbg_state;

  modport master (
    output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, oor_clr,
    input  wb_rdt, wb_ack, oor, dbg_state
  );

  modport slave (
    input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, oor_clr,
    output wb_rdt, wb_ack, oor, dbg_state
  );
endinterface

// File: rtl/serv_dbus_ram.sv
// Wishbone classic data-bus RAM responder for SERV. Captures a request on
// cyc, waits WAIT cycles, then performs a byte-enabled write or a full-word
// read and gives a one-cycle registered ack. Addresses outside the RAM are
// still acknowledged (read data 0, no write) and raise a sticky oor flag.
`timescale 1ns/1ps

module serv_dbus_ram #(
  parameter int          DEPTH = 256,
  parameter int unsigned WAIT  = 1,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  serv_dbus_ram_if.slave  bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [29:0] req_wadr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        req_we;
  logic        ack_q;
  logic [31:0] rdt_q;
  logic        oor_q;

  logic [31:0] mem [DEPTH];

  // Byte bits of the address never select anything; BASE is word aligned so
  // the offset can be formed on word addresses directly (modulo 2^30 words).
  logic        unused_adr_lsb;
  logic [29:0] off_word;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        access;
  logic        mem_we;

  assign unused_adr_lsb = ^bus.wb_adr[1:0];
  assign off_word = req_wadr - BASE[31:2];
  assign in_range = ({2'b00, off_word} < DEPTH_W);
  assign idx      = off_word[AW-1:0];

  // The access edge: still requested and the wait counter has run out.
  assign access = (state == S_BUSY) && bus.wb_cyc && (cnt == 4'd0);
  assign mem_we = access && req_we && in_range;

  // RAM write port; state is reset asynchronously, so a reset cancels mem_we.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[idx][8*b +: 8] <= req_dat[8*b +: 8];
      end
    end
  end

  // Request FSM with registered ack, read data and sticky out-of-range flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_wadr <= '0;
      req_dat  <= '0;
      req_sel  <= '0;
      req_we   <= 1'b0;
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      oor_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      rdt_q <= '0;
      // A clear is overridden below when an out-of-range access lands now.
      if (bus.oor_clr) oor_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.wb_cyc) begin
            req_wadr <= bus.wb_adr[31:2];
            req_dat  <= bus.wb_dat;
            req_sel  <= bus.wb_sel;
            req_we   <= bus.wb_we;
            cnt      <= WAIT_L;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!bus.wb_cyc) begin
            state <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ack_q <= 1'b1;
            state <= S_ACK;
            if (!in_range) oor_q <= 1'b1;
            else if (!req_we) rdt_q <= mem[idx];
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wb_ack    = ack_q;
  assign bus.wb_rdt    = rdt_q;
  assign bus.oor       = oor_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Directed bench for serv_dbus_ram: three instances (WAIT = 1, 3, 0, the last
// at a non-zero BASE) on one clock and one reset. Inputs change and outputs
// are sampled on the falling edge.
`timescale 1ns/1ps

module tb_serv_dbus_ram;

  localparam int W1 = 0;
  localparam int W3 = 1;
  localparam int W0 = 2;
  localparam logic [31:0] BASE0 = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  serv_dbus_ram_if bw1();
  serv_dbus_ram_if bw3();
  serv_dbus_ram_if bw0();

  serv_dbus_ram #(.DEPTH(256), .WAIT(1), .BASE(32'h0000_0000)) u_w1 (
    .i_clk(clk), .i_rst(rst), .bus(bw1)
  );
  serv_dbus_ram #(.DEPTH(256), .WAIT(3), .BASE(32'h0000_0000)) u_w3 (
    .i_clk(clk), .i_rst(rst), .bus(bw3)
  );
  serv_dbus_ram #(.DEPTH(256), .WAIT(0), .BASE(BASE0)) u_w0 (
    .i_clk(clk), .i_rst(rst), .bus(bw0)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int w, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    case (w)
      W1: begin bw1.wb_cyc = cyc; bw1.wb_we = we; bw1.wb_adr = adr; bw1.wb_dat = dat; bw1.wb_sel = sel; end
      W3: begin bw3.wb_cyc = cyc; bw3.wb_we = we; bw3.wb_adr = adr; bw3.wb_dat = dat; bw3.wb_sel = sel; end
      default: begin bw0.wb_cyc = cyc; bw0.wb_we = we; bw0.wb_adr = adr; bw0.wb_dat = dat; bw0.wb_sel = sel; end
    endcase
  endtask

  task automatic set_clr(input int w, input logic v);
    case (w)
      W1: bw1.oor_clr = v;
      W3: bw3.oor_clr = v;
      default: bw0.oor_clr = v;
    endcase
  endtask

  function automatic logic get_ack(input int w);
    case (w)
      W1: return bw1.wb_ack;
      W3: return bw3.wb_ack;
      default: return bw0.wb_ack;
    endcase
  endfunction

  function automatic logic [31:0] get_rdt(input int w);
    case (w)
      W1: return bw1.wb_rdt;
      W3: return bw3.wb_rdt;
      default: return bw0.wb_rdt;
    endcase
  endfunction

  function automatic logic get_oor(input int w);
    case (w)
      W1: return bw1.oor;
      W3: return bw3.oor;
      default: return bw0.oor;
    endcase
  endfunction

  function automatic logic [1:0] get_state(input int w);
    case (w)
      W1: return bw1.dbg_state;
      W3: return bw3.dbg_state;
      default: return bw0.dbg_state;
    endcase
  endfunction

  function automatic int exp_lat(input int w);
    case (w)
      W1: return 3;
      W3: return 5;
      default: return 2;
    endcase
  endfunction

  // One SERV-style transfer started at a falling edge: cyc is dropped in the
  // ack cycle. Latency counts rising edges, the sampling edge being edge 1.
  task automatic xfer(input int w, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input string tag, output logic [31:0] rdt);
    int lat;
    lat = -1;
    rdt = 32'hx;
    drive(w, 1'b1, we, adr, dat, sel);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_ack(w)) begin
        rdt = get_rdt(w);
        lat = e;
        break;
      end
    end
    drive(w, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(w)));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, {31'b0, get_ack(w)}, 32'h0);
    check({tag, "_rdt_after_ack"}, get_rdt(w), 32'h0);
  endtask

  task automatic wr(input int w, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input string tag);
    logic [31:0] r;
    xfer(w, 1'b1, adr, dat, sel, tag, r);
    check({tag, "_wr_rdt"}, r, 32'h0);
  endtask

  task automatic rd(input int w, input logic [31:0] adr, input string tag);
    logic [31:0] r;
    logic [31:0] e;
    xfer(w, 1'b0, adr, 32'h0, 4'h0, tag, r);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, r, 32'hx);
    end else begin
      e = exp_q.pop_front();
      check(tag, r, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    drive(W1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(W3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(W0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_clr(W1, 1'b0);
    set_clr(W3, 1'b0);
    set_clr(W0, 1'b0);

    // Reset values
    #3 rst = 1'b1;
    #1;
    check("rst_ack",   {31'b0, get_ack(W1)}, 32'h0);
    check("rst_rdt",   get_rdt(W1), 32'h0);
    check("rst_oor",   {31'b0, get_oor(W1)}, 32'h0);
    check("rst_state", {30'b0, get_state(W3)}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic write / readback, WAIT = 1
    wr(W1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, "basic_wr");
    exp_q.push_back(32'hDEAD_BEEF);
    rd(W1, 32'h0000_0008, "basic_rd");

    // Byte-enable write over 0xAAAAAAAA
    wr(W1, 32'h0000_0010, 32'hAAAA_AAAA, 4'hF, "be_fill");
    wr(W1, 32'h0000_0010, 32'h1122_3344, 4'b0101, "be_wr");
    exp_q.push_back(32'hAA22_AA44);
    rd(W1, 32'h0000_0010, "be_rd");

    // Out-of-range write (1024 would alias word 0 if the range check failed)
    wr(W1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, "oor_pre");
    check("oor_clear_before", {31'b0, get_oor(W1)}, 32'h0);
    wr(W1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, "oor_wr");
    check("oor_set", {31'b0, get_oor(W1)}, 32'h1);
    repeat (3) @(negedge clk);
    check("oor_sticky", {31'b0, get_oor(W1)}, 32'h1);
    exp_q.push_back(32'h0BAD_F00D);
    rd(W1, 32'h0000_0000, "oor_rd_word0");
    set_clr(W1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_clr(W1, 1'b0);
    check("oor_cleared", {31'b0, get_oor(W1)}, 32'h0);

    // Clear on the same edge as a new out-of-range access: set wins
    drive(W1, 1'b1, 1'b1, 32'h0000_2000, 32'h0, 4'hF);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    set_clr(W1, 1'b1);
    @(posedge clk); @(negedge clk);
    set_clr(W1, 1'b0);
    drive(W1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("oor_same_edge_ack", {31'b0, get_ack(W1)}, 32'h1);
    check("oor_same_edge_set", {31'b0, get_oor(W1)}, 32'h1);
    @(posedge clk); @(negedge clk);
    check("oor_same_edge_hold", {31'b0, get_oor(W1)}, 32'h1);

    // Non-zero BASE: an address just below BASE wraps far out of range
    wr(W0, BASE0 - 32'h4, 32'h0, 4'hF, "below_base");
    check("below_base_oor", {31'b0, get_oor(W0)}, 32'h1);

    // Abort after 2 cycles of BUSY, WAIT = 3
    wr(W3, 32'h0000_0004, 32'h1234_5678, 4'hF, "abort_pre");
    acks = 0;
    drive(W3, 1'b1, 1'b1, 32'h0000_0004, 32'h5555_5555, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      acks += int'(get_ack(W3));
    end
    drive(W3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      acks += int'(get_ack(W3));
    end
    check("abort_no_ack", 32'(acks), 32'h0);
    check("abort_idle", {30'b0, get_state(W3)}, 32'h0);
    exp_q.push_back(32'h1234_5678);
    rd(W3, 32'h0000_0004, "abort_rd");

    // Asynchronous reset during BUSY of a write
    wr(W3, 32'h0000_000C, 32'hCAFE_0001, 4'hF, "rst_pre");
    drive(W3, 1'b1, 1'b1, 32'h0000_000C, 32'hDEAD_DEAD, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_state", {30'b0, get_state(W3)}, 32'h0);
    check("midrst_ack",   {31'b0, get_ack(W3)}, 32'h0);
    check("midrst_rdt",   get_rdt(W3), 32'h0);
    check("midrst_oor_w1", {31'b0, get_oor(W1)}, 32'h0);
    check("midrst_oor_w0", {31'b0, get_oor(W0)}, 32'h0);
    @(negedge clk);
    drive(W3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'hCAFE_0001);
    rd(W3, 32'h0000_000C, "midrst_rd");

    // Zero wait states at BASE 0x8000_0000, back-to-back SERV-style reads
    for (int i = 0; i < 4; i++) begin
      wr(W0, BASE0 + 32'(4 * i), 32'h0101_0101 * 32'(i + 1) ^ 32'hF0F0_0000, 4'hF, "w0_wr");
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0101_0101 * 32'(i + 1) ^ 32'hF0F0_0000);
      rd(W0, BASE0 + 32'(4 * i), $sformatf("w0_rd%0d", i));
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
